// File: rtl/gray_conv_pkg.sv
// Shared types and reference functions for the pipelined Binary/Gray converter.
// The reference functions work on zero-extended 64-bit words, so any width up to 64 can use them.
package gray_conv_pkg;

    typedef enum logic {
        MODE_BIN2GRAY = 1'b0,
        MODE_GRAY2BIN = 1'b1
    } mode_e;

    function automatic int calc_num_stages(input int width, input int bps);
        return (width + bps - 32'sd1) / bps;
    endfunction

    function automatic logic [63:0] bin2gray(input logic [63:0] b);
        return b ^ (b >> 1'b1);
    endfunction

    function automatic logic [63:0] gray2bin(input logic [63:0] g);
        logic [63:0] b;
        b[63] = g[63];
        for (int i = 62; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_conv_stage.sv
// One converter pipeline stage: valid/mode/word register plus this stage's slice of the Gray->binary prefix-XOR.
// The word carries resolved binary bits above the slice and still-unresolved Gray bits below it.
module gray_conv_stage
    import gray_conv_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int BITS_PER_STAGE = 4,
    parameter int STAGE_IDX      = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  adv_i,
    input  logic                  up_valid_i,
    input  mode_e                 up_mode_i,
    input  logic [DATA_WIDTH-1:0] up_word_i,
    output logic                  valid_o,
    output mode_e                 mode_o,
    output logic [DATA_WIDTH-1:0] word_o
);

    localparam int HI     = DATA_WIDTH - 32'sd1 - STAGE_IDX * BITS_PER_STAGE;
    localparam int LO_RAW = DATA_WIDTH - (STAGE_IDX + 32'sd1) * BITS_PER_STAGE;
    localparam int LO     = (LO_RAW > 32'sd0) ? LO_RAW : 32'sd0;

    logic                  valid_d, valid_q;
    mode_e                 mode_d, mode_q;
    logic [DATA_WIDTH-1:0] word_d, word_q;
    logic [DATA_WIDTH-1:0] resolved_s;
    logic                  carry_s;

    // Resolve this stage's bit slice and decide whether to load the upstream word.
    always_comb begin
        valid_d    = valid_q;
        mode_d     = mode_q;
        word_d     = word_q;
        resolved_s = up_word_i;
        carry_s    = 1'b0;
        if (up_mode_i == MODE_GRAY2BIN) begin
            // Seed from the lowest bit the previous stage resolved (none for the first stage).
            for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
                if (i == HI + 1) begin
                    carry_s = up_word_i[i];
                end else if ((i <= HI) && (i >= LO)) begin
                    carry_s       = carry_s ^ up_word_i[i];
                    resolved_s[i] = carry_s;
                end else begin
                    carry_s = carry_s;
                end
            end
        end else begin
            resolved_s = up_word_i;
        end
        if (adv_i) begin
            valid_d = up_valid_i;
            if (up_valid_i) begin
                mode_d = up_mode_i;
                word_d = resolved_s;
            end else begin
                word_d = word_q;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Stage state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            mode_q  <= MODE_BIN2GRAY;
            word_q  <= '0;
        end else begin
            valid_q <= valid_d;
            mode_q  <= mode_d;
            word_q  <= word_d;
        end
    end

    assign valid_o = valid_q;
    assign mode_o  = mode_q;
    assign word_o  = word_q;

endmodule

// File: rtl/gray_code_converter_pipe.sv
// Pipelined bidirectional Binary/Gray converter with valid/ready on both sides.
// Binary->Gray is done on stage-0 entry; Gray->binary is spread over NUM_STAGES stages.
module gray_code_converter_pipe
    import gray_conv_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int BITS_PER_STAGE = 4
) (
    input  logic                  Clock_In,
    input  logic                  Reset_n_In,
    input  logic                  Enable_In,
    input  logic                  Mode_In,
    input  logic                  In_Valid_In,
    output logic                  In_Ready_Out,
    input  logic [DATA_WIDTH-1:0] Data_In,
    output logic                  Out_Valid_Out,
    input  logic                  Out_Ready_In,
    output logic [DATA_WIDTH-1:0] Data_Out,
    output logic                  Mode_Out
);

    localparam int NUM_STAGES = calc_num_stages(DATA_WIDTH, BITS_PER_STAGE);

    logic [NUM_STAGES-1:0] valid_s;
    logic [NUM_STAGES-1:0] adv_s;
    mode_e                 mode_s [NUM_STAGES];
    logic [DATA_WIDTH-1:0] word_s [NUM_STAGES];
    logic                  nxt_s;

    // Advance chain, evaluated from the output end back to the input.
    always_comb begin
        adv_s = '0;
        nxt_s = Out_Ready_In;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            adv_s[k] = Enable_In & (~valid_s[k] | nxt_s);
            nxt_s    = adv_s[k];
        end
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        logic                  up_valid_s;
        mode_e                 up_mode_s;
        logic [DATA_WIDTH-1:0] up_word_s;

        if (k == 0) begin : g_head
            assign up_valid_s = In_Valid_In;
            assign up_mode_s  = mode_e'(Mode_In);
            assign up_word_s  = (Mode_In == MODE_GRAY2BIN) ? Data_In : (Data_In ^ (Data_In >> 1'b1));
        end else begin : g_body
            assign up_valid_s = valid_s[k-1];
            assign up_mode_s  = mode_s[k-1];
            assign up_word_s  = word_s[k-1];
        end

        gray_conv_stage #(
            .DATA_WIDTH    (DATA_WIDTH),
            .BITS_PER_STAGE(BITS_PER_STAGE),
            .STAGE_IDX     (k)
        ) u_stage (
            .clk_i     (Clock_In),
            .rst_n_i   (Reset_n_In),
            .adv_i     (adv_s[k]),
            .up_valid_i(up_valid_s),
            .up_mode_i (up_mode_s),
            .up_word_i (up_word_s),
            .valid_o   (valid_s[k]),
            .mode_o    (mode_s[k]),
            .word_o    (word_s[k])
        );
    end

    // Ready is forced low while reset is held so nothing is taken in during reset.
    assign In_Ready_Out  = adv_s[0] & Reset_n_In;
    assign Out_Valid_Out = valid_s[NUM_STAGES-1];
    assign Data_Out      = word_s[NUM_STAGES-1];
    assign Mode_Out      = mode_s[NUM_STAGES-1];

endmodule

// File: tb/tb_gray_code_converter_pipe.sv
// Scoreboard bench for gray_code_converter_pipe: default 8/4 instance plus three 13-bit sweep instances.
module tb_gray_code_converter_pipe;
    import gray_conv_pkg::*;

    typedef struct {
        logic [63:0] data;
        logic        mode;
        int          issue;
    } sb_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en, mode_in, in_valid, in_ready, out_valid, out_ready, mode_out;
    logic [7:0] data_in, data_out;

    logic        sw_valid, sw_mode;
    logic [12:0] sw_data;
    logic        rdy_a, rdy_b, rdy_c, ov_a, ov_b, ov_c, mo_a, mo_b, mo_c;
    logic [12:0] do_a, do_b, do_c;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    logic lat_chk = 1'b0;
    sb_t  q[$], qa[$], qb[$], qc[$];

    always @(posedge clk) cyc <= cyc + 1;

    gray_code_converter_pipe u_dut (
        .Clock_In(clk), .Reset_n_In(rst_n), .Enable_In(en), .Mode_In(mode_in),
        .In_Valid_In(in_valid), .In_Ready_Out(in_ready), .Data_In(data_in),
        .Out_Valid_Out(out_valid), .Out_Ready_In(out_ready), .Data_Out(data_out),
        .Mode_Out(mode_out)
    );

    gray_code_converter_pipe #(.DATA_WIDTH(13), .BITS_PER_STAGE(1)) u_sw_a (
        .Clock_In(clk), .Reset_n_In(rst_n), .Enable_In(1'b1), .Mode_In(sw_mode),
        .In_Valid_In(sw_valid), .In_Ready_Out(rdy_a), .Data_In(sw_data),
        .Out_Valid_Out(ov_a), .Out_Ready_In(1'b1), .Data_Out(do_a), .Mode_Out(mo_a)
    );

    gray_code_converter_pipe #(.DATA_WIDTH(13), .BITS_PER_STAGE(4)) u_sw_b (
        .Clock_In(clk), .Reset_n_In(rst_n), .Enable_In(1'b1), .Mode_In(sw_mode),
        .In_Valid_In(sw_valid), .In_Ready_Out(rdy_b), .Data_In(sw_data),
        .Out_Valid_Out(ov_b), .Out_Ready_In(1'b1), .Data_Out(do_b), .Mode_Out(mo_b)
    );

    gray_code_converter_pipe #(.DATA_WIDTH(13), .BITS_PER_STAGE(13)) u_sw_c (
        .Clock_In(clk), .Reset_n_In(rst_n), .Enable_In(1'b1), .Mode_In(sw_mode),
        .In_Valid_In(sw_valid), .In_Ready_Out(rdy_c), .Data_In(sw_data),
        .Out_Valid_Out(ov_c), .Out_Ready_In(1'b1), .Data_Out(do_c), .Mode_Out(mo_c)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_conv(input logic m, input logic [63:0] d);
        return m ? gray2bin(d) : bin2gray(d);
    endfunction

    // Present one word on the default DUT and hold it until accepted; push its expectation on acceptance.
    task automatic send_word(input logic m, input logic [7:0] d, input logic [7:0] e);
        int   waited = 0;
        logic acc;
        in_valid = 1'b1;
        mode_in  = m;
        data_in  = d;
        do begin
            @(negedge clk);
            acc = in_ready;
            if (acc) q.push_back('{data: {56'd0, e}, mode: m, issue: cyc});
            @(posedge clk);
            #1;
            waited++;
        end while (!acc && waited < 50);
        check_eq("send_accept", acc, 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q.size() + qa.size() + qb.size() + qc.size()) != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq("drain_empty", q.size() + qa.size() + qb.size() + qc.size(), 0);
    endtask

    task automatic sw_cmp(input string tag, input sb_t e, input logic [12:0] d, input logic m, input int exp_lat);
        check_eq({tag, "_data"}, d, e.data);
        check_eq({tag, "_mode"}, m, e.mode);
        check_eq({tag, "_latency"}, cyc - e.issue, exp_lat);
    endtask

    // Default-DUT monitor: hold stability, disabled-ready, and in-order scoreboard pops.
    logic       hold_pend = 1'b0;
    logic [7:0] hold_data;
    logic       hold_mode;
    sb_t        e_main;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check_eq("hold_valid", out_valid, 1);
                check_eq("hold_data", data_out, hold_data);
                check_eq("hold_mode", mode_out, hold_mode);
            end
            if (!en) check_eq("dis_in_ready", in_ready, 0);
            if (out_valid && out_ready && en) begin
                check_eq("sb_nonempty", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e_main = q.pop_front();
                    check_eq("out_data", data_out, e_main.data);
                    check_eq("out_mode", mode_out, e_main.mode);
                    if (lat_chk) check_eq("latency", cyc - e_main.issue, 2);
                end
            end
            hold_pend = out_valid && !(out_ready && en);
            hold_data = data_out;
            hold_mode = mode_out;
        end
    end

    // Sweep monitors: each 13-bit instance has its own queue and fixed latency.
    always @(negedge clk) begin
        if (rst_n && ov_a) begin
            check_eq("sw1_nonempty", qa.size() != 0, 1);
            if (qa.size() != 0) sw_cmp("sw1", qa.pop_front(), do_a, mo_a, 13);
        end
        if (rst_n && ov_b) begin
            check_eq("sw4_nonempty", qb.size() != 0, 1);
            if (qb.size() != 0) sw_cmp("sw4", qb.pop_front(), do_b, mo_b, 4);
        end
        if (rst_n && ov_c) begin
            check_eq("sw13_nonempty", qc.size() != 0, 1);
            if (qc.size() != 0) sw_cmp("sw13", qc.pop_front(), do_c, mo_c, 1);
        end
    end

    initial begin
        logic [7:0]  d;
        logic [63:0] ex;
        rst_n = 1'b0; en = 1'b1; out_ready = 1'b1; in_valid = 1'b0; mode_in = 1'b0; data_in = 8'h00;
        sw_valid = 1'b0; sw_mode = 1'b0; sw_data = 13'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_data_out", data_out, 0);
        check_eq("rst_mode_out", mode_out, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Known vectors in both modes, then a mixed-mode stream, all at full throughput.
        lat_chk = 1'b1;
        send_word(1'b0, 8'h80, 8'hC0);
        send_word(1'b0, 8'hFF, 8'h80);
        send_word(1'b0, 8'h2D, 8'h3B);
        send_word(1'b1, 8'hC0, 8'h80);
        send_word(1'b1, 8'hFF, 8'hAA);
        send_word(1'b1, 8'h3B, 8'h2D);
        for (int i = 0; i < 16; i++) begin
            d  = 8'($urandom_range(0, 255));
            ex = ref_conv(1'(i), {56'd0, d});
            send_word(1'(i), d, ex[7:0]);
        end
        in_valid = 1'b0;
        wait_drain();
        lat_chk = 1'b0;

        // Backpressure for 5 cycles under a continuous stream.
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    d  = 8'($urandom_range(0, 255));
                    ex = ref_conv(1'(i >> 1), {56'd0, d});
                    send_word(1'(i >> 1), d, ex[7:0]);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                @(negedge clk);
                check_eq("bp_in_ready", in_ready, 0);
                check_eq("bp_out_valid", out_valid, 1);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();

        // Enable low for 3 cycles mid-stream, downstream still ready.
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    d  = 8'($urandom_range(0, 255));
                    ex = ref_conv(1'($urandom_range(0, 1)), {56'd0, d});
                    send_word(1'(ex != bin2gray({56'd0, d})), d, ex[7:0]);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 en = 1'b0;
                repeat (3) @(posedge clk);
                #1 en = 1'b1;
            end
        join
        wait_drain();

        // Reset with two words in flight: outputs clear asynchronously and nothing stale appears.
        ex = ref_conv(1'b0, 64'hA5);
        send_word(1'b0, 8'hA5, ex[7:0]);
        ex = ref_conv(1'b1, 64'h3C);
        send_word(1'b1, 8'h3C, ex[7:0]);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", out_valid, 0);
        check_eq("arst_data_out", data_out, 0);
        check_eq("arst_mode_out", mode_out, 0);
        check_eq("arst_in_ready", in_ready, 0);
        q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("post_rst_idle", out_valid, 0);
        end
        @(posedge clk);
        #1;
        ex = ref_conv(1'b1, 64'h5A);
        send_word(1'b1, 8'h5A, ex[7:0]);
        in_valid = 1'b0;
        wait_drain();

        // Exhaustive 13-bit sweep in both modes across three stage splits.
        for (int m = 0; m < 2; m++) begin
            for (int v = 0; v < 8192; v++) begin
                sw_valid = 1'b1;
                sw_mode  = 1'(m);
                sw_data  = 13'(v);
                @(negedge clk);
                check_eq("sw_ready", rdy_a & rdy_b & rdy_c, 1);
                ex = ref_conv(1'(m), 64'(v));
                qa.push_back('{data: ex, mode: 1'(m), issue: cyc});
                qb.push_back('{data: ex, mode: 1'(m), issue: cyc});
                qc.push_back('{data: ex, mode: 1'(m), issue: cyc});
                @(posedge clk);
                #1;
            end
        end
        sw_valid = 1'b0;
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
